// File: rtl/clk_div_cfg_pkg.sv
// Shared state encoding and default constants for the clock-divider configuration sequencer.
package clk_div_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD,
        RESUME,
        ACK
    } state_t;

    localparam int DEF_RATIO_W       = 8;
    localparam int DEF_SETTLE_CYC    = 4;
    localparam int DEF_DEFAULT_RATIO = 2;

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or above ptr, wrapping, wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[wrap_idx(ptr, i)]) begin
                found   = 1'b1;
                gnt_idx = wrap_idx(ptr, i);
            end
        end
        gnt_oh[gnt_idx] = found;
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider configuration sequencer: arbitrates ratio requests and applies them with a safe
// disable/settle/load/enable/settle/grant order. Optional lock input enabled by CLK_DIV_CFG_LOCK_EN.
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int RATIO_W       = DEF_RATIO_W,
    parameter int N_REQ         = 2,
    parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int DEFAULT_RATIO = DEF_DEFAULT_RATIO
) (
    input  logic                     i_ref_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*RATIO_W-1:0] i_req_ratio,
`ifdef CLK_DIV_CFG_LOCK_EN
    input  logic                     i_lock,
    output logic                     o_rej,
`endif
    output logic [N_REQ-1:0]         o_gnt,
    output logic                     o_busy,
    output logic                     o_clk_en,
    output logic [RATIO_W-1:0]       o_div_ratio
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [RATIO_W-1:0] RATIO_RST = RATIO_W'(DEFAULT_RATIO);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   winner_reg;
    logic [RATIO_W-1:0] r_ratio_reg;

    logic [N_REQ-1:0]   arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic [RATIO_W-1:0] sel_ratio;
    logic               lock_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (i_req),
        .ptr     (ptr_reg),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    assign sel_ratio = i_req_ratio[int'(arb_idx)*RATIO_W +: RATIO_W];

`ifdef CLK_DIV_CFG_LOCK_EN
    assign lock_hit = i_lock;

    // Reject flag rides alongside the grant issued straight from IDLE.
    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) o_rej <= 1'b0;
        else          o_rej <= (state_reg == IDLE) && (|i_req) && i_lock;
    end
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            winner_reg  <= '0;
            r_ratio_reg <= RATIO_RST;
            o_div_ratio <= RATIO_RST;
            o_clk_en    <= 1'b1;
            o_gnt       <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_gnt <= '0;
            case (state_reg)
                IDLE: begin
                    if (|i_req) begin
                        winner_reg  <= arb_idx;
                        r_ratio_reg <= sel_ratio;
                        cnt_reg     <= '0;
                        o_busy      <= 1'b1;
                        if (lock_hit || (sel_ratio == o_div_ratio)) begin
                            state_reg <= ACK;
                            o_gnt     <= arb_oh;
                        end else begin
                            state_reg <= DRAIN;
                            o_clk_en  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg   <= LOAD;
                        cnt_reg     <= '0;
                        // New ratio is visible for the whole LOAD cycle, while the enable is still low.
                        o_div_ratio <= r_ratio_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= RESUME;
                    cnt_reg   <= '0;
                    o_clk_en  <= 1'b1;
                end
                RESUME: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ACK;
                        cnt_reg   <= '0;
                        o_gnt     <= N_REQ'(1) << winner_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    o_busy    <= 1'b0;
                    ptr_reg   <= (winner_reg == IDX_W'(N_REQ - 1)) ? '0 : winner_reg + 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    o_busy    <= 1'b0;
                    o_clk_en  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios plus randomized transactions
// against a transaction-level model (current ratio, round-robin pointer, expected latency).
module tb_clk_div_cfg_ctrl;

    localparam int RW    = 8;
    localparam int N_REQ = 2;
    localparam int S     = 4;
    localparam int DEFR  = 2;
    localparam int MAXC  = 2 * S + 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req;
    logic [N_REQ*RW-1:0] req_ratio;
    logic [N_REQ-1:0]  gnt;
    logic              busy;
    logic              clk_en;
    logic [RW-1:0]     div_ratio;
    logic              lock = 1'b0;
`ifdef CLK_DIV_CFG_LOCK_EN
    logic              rej;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;
    logic [RW-1:0] m_ratio = RW'(DEFR);

    always #5 clk = ~clk;

    clk_div_cfg_ctrl #(
        .RATIO_W       (RW),
        .N_REQ         (N_REQ),
        .SETTLE_CYC    (S),
        .DEFAULT_RATIO (DEFR)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_req_ratio (req_ratio),
`ifdef CLK_DIV_CFG_LOCK_EN
        .i_lock      (lock),
        .o_rej       (rej),
`endif
        .o_gnt       (gnt),
        .o_busy      (busy),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio)
    );

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ratio = RW'(DEFR);
        m_ptr   = 0;
    endtask

    // One full request/grant transaction. Inputs must already be set; the next edge samples them.
    task automatic run_txn(input logic [N_REQ-1:0] next_req, input logic [N_REQ*RW-1:0] next_ratio,
                           input bit scramble);
        int win, exp_lat, exp_low, gnt_cyc, gnt_cnt, low_cnt, bad_chg, bad_busy, rej_cnt;
        logic [RW-1:0] exp_ratio, new_ratio, prev_ratio;
        logic [N_REQ-1:0] gnt_val, exp_oh;
        logic post_busy, exp_rej;
        bit bypass;
        win = -1;
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (m_ptr + i) % N_REQ;
            if (win < 0 && req[k]) win = k;
        end
        exp_ratio = req_ratio[win*RW +: RW];
        exp_rej   = lock;
        bypass    = lock || (exp_ratio == m_ratio);
        exp_lat   = bypass ? 1 : 2 * S + 2;
        exp_low   = bypass ? 0 : S + 1;
        new_ratio = lock ? m_ratio : exp_ratio;
        exp_oh    = N_REQ'(1) << win;
        gnt_cyc = -1; gnt_cnt = 0; low_cnt = 0; bad_chg = 0; bad_busy = 0; rej_cnt = 0;
        gnt_val = '0; post_busy = 1'b1;
        prev_ratio = div_ratio;
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk); #1;
            if (!clk_en) low_cnt++;
            if (div_ratio !== prev_ratio && clk_en !== 1'b0) bad_chg++;
            prev_ratio = div_ratio;
`ifdef CLK_DIV_CFG_LOCK_EN
            if (rej === 1'b1) rej_cnt++;
`endif
            if (gnt_cyc < 0 && busy !== 1'b1) bad_busy++;
            if (gnt !== '0) begin
                gnt_cnt++;
                if (gnt_cyc < 0) begin
                    gnt_cyc   = c;
                    gnt_val   = gnt;
                    req       = next_req;
                    req_ratio = next_ratio;
                end
            end
            if (scramble && c == 2 && gnt_cyc < 0) begin
                req       = N_REQ'($urandom);
                req_ratio = (N_REQ*RW)'($urandom);
                lock      = 1'($urandom);
            end
            if (gnt_cyc > 0 && c == gnt_cyc + 1) begin
                post_busy = busy;
                break;
            end
        end
        if (scramble) lock = 1'b0;
        n_tests++;
        if (gnt_cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL gnt_latency: got %0d, expected %0d", gnt_cyc, exp_lat);
        end
        n_tests++;
        if (gnt_val !== exp_oh) begin
            n_fail++;
            $display("FAIL gnt_onehot: got %b, expected %b", gnt_val, exp_oh);
        end
        n_tests++;
        if (gnt_cnt !== 1) begin
            n_fail++;
            $display("FAIL gnt_pulse_count: got %0d, expected 1", gnt_cnt);
        end
        n_tests++;
        if (low_cnt !== exp_low) begin
            n_fail++;
            $display("FAIL clk_en_low_cycles: got %0d, expected %0d", low_cnt, exp_low);
        end
        n_tests++;
        if (div_ratio !== new_ratio) begin
            n_fail++;
            $display("FAIL div_ratio: got %0d, expected %0d", div_ratio, new_ratio);
        end
        n_tests++;
        if (bad_chg !== 0) begin
            n_fail++;
            $display("FAIL ratio_change_with_clk_en: got %0d changes, expected 0", bad_chg);
        end
        n_tests++;
        if (bad_busy !== 0 || post_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy: low_while_active=%0d post_grant=%b, expected 0 and 0", bad_busy, post_busy);
        end
`ifdef CLK_DIV_CFG_LOCK_EN
        n_tests++;
        if (rej_cnt !== (exp_rej ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rej_pulse: got %0d, expected %0d", rej_cnt, exp_rej ? 1 : 0);
        end
`endif
        $display("[TB] txn winner=%0d ratio %0d->%0d lock=%0d gnt_cycle=%0d", win, m_ratio, new_ratio,
                 exp_rej, gnt_cyc);
        m_ratio = new_ratio;
        m_ptr   = (win + 1) % N_REQ;
    endtask

    task automatic test_reset();
        logic [RW+N_REQ+1:0] obs, exp_v;
        rst_n = 1'b0; req = '0; req_ratio = '0; lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_v = {RW'(DEFR), 1'b1, 1'b0, N_REQ'(0)};
        obs   = {div_ratio, clk_en, busy, gnt};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h, expected %h", obs, exp_v);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            obs = {div_ratio, clk_en, busy, gnt};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: got %h, expected %h", c, obs, exp_v);
            end
        end
        $display("[TB] reset and 10 idle cycles checked");
        m_ratio = RW'(DEFR);
        m_ptr   = 0;
    endtask

    task automatic test_single();
        req = 2'b01; req_ratio = {8'd0, 8'd8};
        run_txn(2'b00, {8'd0, 8'd8}, 1'b0);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        req = 2'b11; req_ratio = {8'd10, 8'd6};
        run_txn(2'b11, {8'd10, 8'd6}, 1'b0);
        run_txn(2'b01, {8'd10, 8'd6}, 1'b0);
        run_txn(2'b00, {8'd10, 8'd6}, 1'b0);
    endtask

    task automatic test_same_ratio();
        reset_dut();
        req = 2'b01; req_ratio = {8'd5, 8'd2};
        run_txn(2'b00, {8'd5, 8'd2}, 1'b0);
    endtask

    task automatic test_reset_mid();
        int gnt_seen, busy_seen;
        reset_dut();
        req = 2'b01; req_ratio = {8'd0, 8'd9};
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drain_clk_en: got %b, expected 0", clk_en);
        end
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk); #1;
        n_tests++;
        if ({clk_en, div_ratio, gnt, busy} !== {1'b1, RW'(DEFR), N_REQ'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL abort_reset: clk_en=%b ratio=%0d gnt=%b busy=%b, expected 1 %0d 00 0",
                     clk_en, div_ratio, gnt, busy, DEFR);
        end
        rst_n = 1'b1;
        m_ratio = RW'(DEFR);
        m_ptr   = 0;
        gnt_seen = 0; busy_seen = 0;
        for (int c = 0; c < 2 * S + 4; c++) begin
            @(posedge clk); #1;
            if (gnt !== '0) gnt_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        n_tests++;
        if (gnt_seen !== 0 || busy_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_grant: gnt_cycles=%0d busy_cycles=%0d, expected 0 0", gnt_seen, busy_seen);
        end
        $display("[TB] reset during DRAIN checked");
    endtask

    task automatic test_random();
        reset_dut();
        req       = N_REQ'($urandom_range(1, 3));
        req_ratio = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
        for (int t = 0; t < 25; t++) begin
            run_txn(N_REQ'($urandom_range(1, 3)),
                    {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))}, 1'b1);
        end
        req = '0;
    endtask

`ifdef CLK_DIV_CFG_LOCK_EN
    task automatic test_lock();
        reset_dut();
        lock = 1'b1;
        req = 2'b01; req_ratio = {8'd0, 8'd12};
        run_txn(2'b00, {8'd0, 8'd12}, 1'b0);
        lock = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req = '0;
        req_ratio = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_same_ratio();
        test_reset_mid();
        test_random();
`ifdef CLK_DIV_CFG_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
- Configuration sequencer for the system clock divider.
- Accepts divide-ratio change requests from N_REQ requesters (e.g. register-file config, UART prescale logic) and picks one by round-robin.
- Drives the divider's enable and ratio inputs in a safe order: disable, settle, load ratio, re-enable, settle, grant.
- Sits in the ref-clock domain, beside the divider instance.

Parameters:
- RATIO_W, 8: width of the divide ratio.
- N_REQ, 2: number of requesters (2..4).
- SETTLE_CYC, 4: cycles held in each settle phase (>=1).
- DEFAULT_RATIO, 2: ratio driven out of reset.

Ports:
- i_ref_clk  in  1  single clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req  in  N_REQ  per-requester request level, held until grant.
- i_req_ratio  in  N_REQ*RATIO_W  packed requested ratios; requester k uses slice [k*RATIO_W +: RATIO_W].
- o_gnt  out  N_REQ  one-hot, one-cycle completion pulse.
- o_busy  out  1  high whenever state != IDLE.
- o_clk_en  out  1  to divider enable.
- o_div_ratio  out  RATIO_W  to divider ratio.

Behaviour:
- Reset (sampled on i_ref_clk while i_rst_n=0), all outputs registered:
  - o_div_ratio=DEFAULT_RATIO, o_clk_en=1, o_gnt=0, o_busy=0.
  - RR pointer=0, state=IDLE.
- Reset asserted mid-sequence aborts it: no grant is issued, and outputs return to their reset values on the next edge.
- FSM states: IDLE, DRAIN, LOAD, RESUME, ACK.
- IDLE, with any i_req bit high at edge t:
  - Round-robin picks the winner: first set bit at or above the pointer, wrapping.
  - Latch winner index and its ratio into r_ratio.
  - If r_ratio == o_div_ratio: go directly to ACK (o_gnt high the cycle after edge t; o_clk_en never drops).
  - Otherwise: go to DRAIN, with o_clk_en=0 from edge t.
- DRAIN: o_clk_en=0; count SETTLE_CYC cycles, then go to LOAD.
- LOAD: o_div_ratio <= r_ratio on exit; go to RESUME.
- RESUME: o_clk_en=1; count SETTLE_CYC cycles, then go to ACK.
- ACK:
  - o_gnt[winner]=1 for exactly one cycle.
  - Pointer <= winner+1, modulo N_REQ.
  - Return to IDLE; i_req is not sampled in ACK.
- Full-path latency: o_gnt is high in cycle 2*SETTLE_CYC+2 after the sampling edge (cycle 1 = the one following edge t).
- o_clk_en low window: exactly SETTLE_CYC+1 cycles (DRAIN plus LOAD).
- o_div_ratio changes only while o_clk_en=0.
- Requests are only evaluated in IDLE. Changes to i_req or i_req_ratio while busy are ignored; the latched r_ratio is used.
- A request withdrawn mid-sequence does not abort it; the grant still pulses.
- Requester k must deassert i_req[k] on the cycle after its o_gnt pulse, or it is re-arbitrated on the next IDLE evaluation.
- Ratios 0 and 1 are passed through unchanged (the divider treats them as bypass); no error is raised.
- Counter width: $clog2(SETTLE_CYC+1). The counter clears on every state entry.

Optional Feature:
- Macro: CLK_DIV_CFG_LOCK_EN.
- Defined:
  - Adds ports i_lock (in, 1) and o_rej (out, 1; reset value 0).
  - If i_lock=1 when a request is selected in IDLE: go to ACK with o_rej=1 for the same cycle as o_gnt; o_clk_en and o_div_ratio are untouched.
  - i_lock is ignored once the sequence has left IDLE.
- Undefined: no i_lock/o_rej ports; every request is honoured.

Decomposition:
- Package clk_div_cfg_pkg holds:
  - State enum: IDLE, DRAIN, LOAD, RESUME, ACK.
  - Default RATIO_W, SETTLE_CYC and DEFAULT_RATIO constants.
- One sub-module: rr_arbiter.
  - Parameter N_REQ.
  - Inputs req and ptr; outputs one-hot gnt_oh and gnt_idx.
  - Purely combinational.
- Sequencing, pointer and datapath registers stay in clk_div_cfg_ctrl.

Test Plan:
- Reset, then idle 10 cycles: o_div_ratio=2, o_clk_en=1, o_busy=0, o_gnt=0 throughout.
- i_req=01, ratio0=8, SETTLE_CYC=4:
  - o_clk_en low for exactly 5 cycles.
  - o_div_ratio becomes 8 while o_clk_en=0.
  - o_gnt=01 in cycle 10, one cycle only.
  - o_busy low the cycle after the grant.
- i_req=11 held, ratios 6/10, pointer=0:
  - Grants in order 01 then 10, with o_div_ratio going 6 then 10.
  - Then drop i_req[1] and hold i_req[0] with ratio 6: grant 01 again.
- Same-ratio request (ratio0=current value 2): o_gnt pulses the cycle after the sampling edge; o_clk_en stays 1 throughout.
- Reset asserted during DRAIN: next edge gives o_clk_en=1, o_div_ratio=2, no o_gnt pulse, state IDLE.
- With CLK_DIV_CFG_LOCK_EN defined, i_lock=1 and a request with ratio 12: o_gnt and o_rej pulse together; o_div_ratio stays 2; o_clk_en never drops.
